// File: rtl/io_input_conditioner.sv
// Board input conditioning: synchronises the switches, debounces the push button,
// and produces press/release pulses, a sticky pending flag and a switch snapshot.
module io_input_conditioner #(
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button_raw,
  input  logic [SW_WIDTH-1:0] switches_raw,
  input  logic                ack,
  output logic [SW_WIDTH-1:0] switches,
  output logic [SW_WIDTH-1:0] snapshot,
  output logic                button_level,
  output logic                button_on,
  output logic                button_off,
  output logic                pending
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CNT   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CNT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0]               btn_sync;
  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync;
  logic                                 btn_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d, on_d, off_d;

  // Synchroniser chains; the last stage is the live switch output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync <= '0;
      sw_sync  <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], button_raw};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], switches_raw};
    end
  end

  assign btn_s    = btn_sync[SYNC_STAGES-1];
  assign switches = sw_sync[SYNC_STAGES-1];

  // Debounce FSM: a level change is accepted after DEBOUNCE_CYCLES agreeing samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = button_level;
    on_d    = 1'b0;
    off_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_CNT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_CNT: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          on_d    = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_CNT;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_CNT: begin
        if (btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          off_d   = 1'b1;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; a press beats a simultaneous ack on pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      button_level <= 1'b0;
      button_on    <= 1'b0;
      button_off   <= 1'b0;
      pending      <= 1'b0;
      snapshot     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      button_level <= level_d;
      button_on    <= on_d;
      button_off   <= off_d;
      if (on_d) begin
        snapshot <= switches;
        pending  <= 1'b1;
      end else if (ack) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed scenarios plus random stimulus against
// a delay-line / run-length reference model.
module tb_io_input_conditioner;

  localparam int unsigned SW   = 16;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          button_raw = 1'b0;
  logic [SW-1:0] switches_raw = '0;
  logic          ack = 1'b0;
  logic [SW-1:0] switches, snapshot;
  logic          button_level, button_on, button_off, pending;

  int compared = 0;
  int mismatched = 0;

  io_input_conditioner #(.SW_WIDTH(SW), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .button_raw(button_raw), .switches_raw(switches_raw), .ack(ack),
    .switches(switches), .snapshot(snapshot), .button_level(button_level),
    .button_on(button_on), .button_off(button_off), .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: raw inputs pass through SYNC-deep delay lines; the accepted
  // level flips once the delayed button has disagreed with it DEB samples in a row.
  logic          m_bq [SYNC];
  logic [SW-1:0] m_swq[SYNC];
  int            m_run;
  logic          m_level, m_on, m_off, m_pend;
  logic [SW-1:0] m_snap;

  task automatic model_clear();
    for (int i = 0; i < int'(SYNC); i++) begin
      m_bq[i]  = 1'b0;
      m_swq[i] = '0;
    end
    m_run = 0; m_level = 1'b0; m_on = 1'b0; m_off = 1'b0; m_pend = 1'b0; m_snap = '0;
  endtask

  task automatic model_step();
    logic s;
    s = m_bq[SYNC-1];
    m_on = 1'b0;
    m_off = 1'b0;
    if (s != m_level) begin
      m_run++;
      if (m_run == int'(DEB)) begin
        m_level = s; m_on = s; m_off = !s; m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    if (m_on) m_snap = m_swq[SYNC-1];
    if (m_on) m_pend = 1'b1;
    else if (ack) m_pend = 1'b0;
    for (int i = int'(SYNC) - 1; i > 0; i--) begin
      m_bq[i]  = m_bq[i-1];
      m_swq[i] = m_swq[i-1];
    end
    m_bq[0]  = button_raw;
    m_swq[0] = switches_raw;
  endtask

  function automatic logic [2*SW+3:0] dut_vec();
    return {switches, snapshot, button_level, button_on, button_off, pending};
  endfunction

  function automatic logic [2*SW+3:0] mdl_vec();
    return {m_swq[SYNC-1], m_snap, m_level, m_on, m_off, m_pend};
  endfunction

  // One clock: the model advances on the edge, outputs are then sampled at negedge.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_clear();
    else model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_clear();
    repeat (3) cyc();
    compared++;
    if (dut_vec() !== '0) begin
      mismatched++;
      $display("FAIL reset_state got=%h exp=0", dut_vec());
    end
    rst = 1'b0;
    repeat (3) cyc();
    compared++;
    if (dut_vec() !== mdl_vec()) begin
      mismatched++;
      $display("FAIL reset_idle got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_switch_path();
    switches_raw = 16'hFFFF;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      compared++;
      if (switches !== ((k >= 2) ? 16'hFFFF : 16'h0000) || snapshot !== 16'h0000
          || dut_vec() !== mdl_vec()) begin
        mismatched++;
        $display("FAIL switch_path k=%0d got sw=%h snap=%h exp sw=%h snap=0000",
                 k, switches, snapshot, (k >= 2) ? 16'hFFFF : 16'h0000);
      end
    end
  endtask

  task automatic test_clean_press();
    switches_raw = 16'h00A5;
    repeat (4) cyc();
    button_raw = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      compared++;
      if (button_on !== (k == 6) || button_level !== (k >= 6) || button_off !== 1'b0
          || dut_vec() !== mdl_vec()) begin
        mismatched++;
        $display("FAIL clean_press k=%0d got on=%b lvl=%b vec=%h exp on=%b lvl=%b vec=%h",
                 k, button_on, button_level, dut_vec(), k == 6, k >= 6, mdl_vec());
      end
    end
    compared++;
    if (pending !== 1'b1 || snapshot !== 16'h00A5) begin
      mismatched++;
      $display("FAIL press_capture got pend=%b snap=%h exp pend=1 snap=00a5", pending, snapshot);
    end
  endtask

  task automatic test_release();
    button_raw = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      compared++;
      if (button_off !== (k == 6) || button_level !== (k < 6) || button_on !== 1'b0
          || pending !== 1'b1 || dut_vec() !== mdl_vec()) begin
        mismatched++;
        $display("FAIL release k=%0d got off=%b lvl=%b pend=%b exp off=%b lvl=%b pend=1",
                 k, button_off, button_level, pending, k == 6, k < 6);
      end
    end
  endtask

  task automatic test_bounce();
    button_raw = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      compared++;
      if (button_on !== (k == 10) || button_level !== (k >= 10) || dut_vec() !== mdl_vec()) begin
        mismatched++;
        $display("FAIL bounce k=%0d got on=%b lvl=%b exp on=%b lvl=%b",
                 k, button_on, button_level, k == 10, k >= 10);
      end
      button_raw = (k == 3) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic test_ack_collision();
    button_raw = 1'b0;
    repeat (10) cyc();
    button_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      compared++;
      if (button_on !== (k == 6) || pending !== (k < 9) || dut_vec() !== mdl_vec()) begin
        mismatched++;
        $display("FAIL ack_collision k=%0d got on=%b pend=%b exp on=%b pend=%b",
                 k, button_on, pending, k == 6, k < 9);
      end
      ack = (k == 5 || k == 8);
    end
    ack = 1'b0;
  endtask

  task automatic test_reset_midcount();
    button_raw = 1'b0;
    repeat (10) cyc();
    button_raw = 1'b1;
    repeat (4) cyc();
    rst = 1'b1;
    model_clear();
    #1;
    compared++;
    if (dut_vec() !== '0) begin
      mismatched++;
      $display("FAIL reset_async got=%h exp=0", dut_vec());
    end
    @(negedge clk);
    cyc();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      compared++;
      if (button_on !== (k == 6) || button_level !== (k >= 6) || dut_vec() !== mdl_vec()) begin
        mismatched++;
        $display("FAIL reset_midcount k=%0d got on=%b lvl=%b exp on=%b lvl=%b",
                 k, button_on, button_level, k == 6, k >= 6);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold == 0) begin
        button_raw = ~button_raw;
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(1, 6));
      end
      hold--;
      if ($urandom_range(0, 7) == 0) switches_raw = SW'($urandom);
      ack = ($urandom_range(0, 7) == 0);
      cyc();
      compared++;
      if (dut_vec() !== mdl_vec() || (button_on && button_off)) begin
        mismatched++;
        $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_switch_path();
    test_clean_press();
    test_release();
    test_bounce();
    test_ack_collision();
    test_reset_midcount();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
